// File: rtl/arm_fetch_unit_if.sv
`default_nettype none
// =============================================================================
// Module   : arm_fetch_unit_if
// Brief    : Instruction-memory bus, redirect and decode handshake of the fetch unit
// Revision : 1.0
// =============================================================================
interface arm_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/arm_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : arm_fetch_unit
// Brief    : Fetch front-end: PC, req/gnt memory reads, prefetch FIFO, redirect
// Revision : 1.0
// =============================================================================
module arm_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    arm_fetch_unit_if.master bus
);
    localparam int unsigned          c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned          c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = (c_PTR_W)'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = (c_CNT_W)'(1);
    localparam logic [c_CNT_W:0]     c_DEPTH   = (c_CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_fetch_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;
    logic [c_CNT_W-1:0] r_fifo_count;
    logic [c_PTR_W-1:0] r_pcq_wr, r_pcq_rd;
    logic [c_PTR_W-1:0] r_fifo_wr, r_fifo_rd;
    logic [31:0]        r_pcq       [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];

    logic               w_req, w_grant, w_resp, w_push, w_pop, w_inst_valid;
    logic [c_CNT_W-1:0] w_out_next, w_fifo_count_next;
    logic [31:0]        w_redirect_target;

    // Outstanding requests and buffered words share one budget so a response always has a slot.
    assign w_req  = (r_state != S_BOOT) &&
                    (({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < c_DEPTH);
    assign w_grant = w_req && bus.imem_gnt;
    assign w_resp  = bus.imem_rvalid && (r_outstanding != '0);
    assign w_push  = w_resp && (r_discard == '0) && !bus.redirect_valid;
    assign w_inst_valid = (r_fifo_count != '0);
    assign w_pop   = w_inst_valid && bus.inst_ready;
    assign w_redirect_target = bus.redirect_pc & ~32'h0000_0003;

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst       = w_inst_valid ? r_fifo_data[r_fifo_rd] : 32'h0;
    assign bus.inst_pc    = w_inst_valid ? r_fifo_pc[r_fifo_rd]   : 32'h0;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_grant && !w_resp) begin
            w_out_next = r_outstanding + c_CNT_ONE;
        end else if (!w_grant && w_resp) begin
            w_out_next = r_outstanding - c_CNT_ONE;
        end
    end

    always_comb begin
        w_fifo_count_next = r_fifo_count;
        if (w_push && !w_pop) begin
            w_fifo_count_next = r_fifo_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_fifo_count_next = r_fifo_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fifo_count  <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
            r_fifo_wr     <= '0;
            r_fifo_rd     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_grant) r_pcq_wr <= r_pcq_wr + c_PTR_ONE;
            if (w_resp)  r_pcq_rd <= r_pcq_rd + c_PTR_ONE;

            if (bus.redirect_valid) begin
                // Every request still on the bus, including this cycle's grant, is old-stream.
                r_fetch_pc   <= w_redirect_target;
                r_discard    <= w_out_next;
                r_state      <= (w_out_next != '0) ? S_DRAIN : S_RUN;
                r_fifo_count <= '0;
                r_fifo_wr    <= '0;
                r_fifo_rd    <= '0;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - c_CNT_ONE;
                case (r_state)
                    S_BOOT:  r_state <= S_RUN;
                    S_RUN:   r_state <= S_RUN;
                    S_DRAIN: if (w_resp && (r_discard == c_CNT_ONE)) r_state <= S_RUN;
                    default: r_state <= S_BOOT;
                endcase
                if (w_push) r_fifo_wr <= r_fifo_wr + c_PTR_ONE;
                if (w_pop)  r_fifo_rd <= r_fifo_rd + c_PTR_ONE;
                r_fifo_count <= w_fifo_count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) r_pcq[r_pcq_wr] <= r_fetch_pc;
        if (w_push) begin
            r_fifo_data[r_fifo_wr] <= bus.imem_rdata;
            r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_arm_fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_arm_fetch_unit
// Brief    : Scoreboard bench for arm_fetch_unit with a variable-latency memory
// Revision : 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_arm_fetch_unit;
    localparam logic [31:0] c_WRAP_PC = 32'hFFFF_FFF8;

    typedef struct { int due; logic [31:0] data; } resp_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

    logic clk = 1'b0;
    logic rst_n, rst2_n;
    always #5 clk = ~clk;

    arm_fetch_unit_if bus();
    arm_fetch_unit_if bus2();

    arm_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    arm_fetch_unit #(.RESET_PC(c_WRAP_PC), .FIFO_DEPTH(4)) u_dut_wrap (
        .clk(clk), .rst_n(rst2_n), .bus(bus2));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc, lat, epoch, n_grants;
    bit          gnt_en, saw_pc40, want_first, wrap_done;
    logic [31:0] exp_req_pc, first_pc;
    resp_t       pend[$];
    exp_t        sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a, input int ep);
        return (a * 32'h9E37_79B1) ^ {ep[7:0], 24'h5A_5A5A};
    endfunction

    // One bus cycle: memory answers, scoreboard updates, then advance to posedge+1.
    task automatic tick();
        resp_t r;
        exp_t  e;
        bus.imem_gnt = gnt_en && rst_n;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = r.data;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        if (rst_n) begin
            if (bus.inst_valid && bus.inst_ready) begin
                if (sb.size() == 0) begin
                    check("xfer_unexpected", 32'(bus.inst_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("xfer_pc", bus.inst_pc, e.pc);
                    check("xfer_data", bus.inst, e.data);
                end
                if (bus.inst_pc == 32'h40) saw_pc40 = 1'b1;
                if (want_first) begin
                    first_pc   = bus.inst_pc;
                    want_first = 1'b0;
                end
            end
            if (bus.imem_req && bus.imem_gnt) begin
                check("req_addr", bus.imem_addr, exp_req_pc);
                r.due  = cyc + lat;
                r.data = memfn(bus.imem_addr, epoch);
                pend.push_back(r);
                if (!bus.redirect_valid) begin
                    e.pc   = exp_req_pc;
                    e.data = memfn(exp_req_pc, epoch);
                    sb.push_back(e);
                end
                exp_req_pc += 32'd4;
                n_grants++;
            end
            if (bus.redirect_valid) begin
                sb.delete();
                exp_req_pc = bus.redirect_pc & ~32'h3;
            end
        end else begin
            sb.delete();
            exp_req_pc = 32'h0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        epoch++;
        tick();
        tick();
        rst_n = 1'b1;
        n_grants = 0;
    endtask

    initial begin : p_main
        cyc = 0; lat = 1; epoch = 0; n_grants = 0; gnt_en = 1'b1;
        saw_pc40 = 1'b0; want_first = 1'b0; exp_req_pc = 32'h0; first_pc = 32'h0;
        rst_n = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset values and first-fetch latency.
        do_reset();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);
        tick();
        check("t1_req_c1", 32'(bus.imem_req), 32'd1);
        check("t1_addr_c1", bus.imem_addr, 32'h0);
        tick();
        check("t1_valid_c2", 32'(bus.inst_valid), 32'd0);
        tick();
        check("t1_valid_c3", 32'(bus.inst_valid), 32'd1);
        check("t1_pc_c3", bus.inst_pc, 32'h0);
        repeat (8) tick();

        // Back-pressure fills the FIFO and stops fetch.
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        check("t2_grants", 32'(n_grants), 32'd4);
        check("t2_req_off", 32'(bus.imem_req), 32'd0);
        check("t2_valid", 32'(bus.inst_valid), 32'd1);
        check("t2_hold_pc", bus.inst_pc, 32'h0);
        check("t2_hold_inst", bus.inst, memfn(32'h0, epoch));
        bus.inst_ready = 1'b1;
        n_grants = 0;
        repeat (12) tick();
        check("t2_resume", 32'(n_grants >= 4), 32'd1);

        // Redirect with two in flight, one returning, no grant.
        lat = 2;
        do_reset();
        repeat (6) tick();
        for (int i = 0; i < 20 && !(pend.size() == 2 && pend[0].due <= cyc); i++) tick();
        check("t3_setup", 32'(pend.size()), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        gnt_en = 1'b0;
        tick();
        bus.redirect_valid = 1'b0;
        gnt_en = 1'b1;
        want_first = 1'b1;
        first_pc = 32'hFFFF_FFFF;
        check("t3_addr", bus.imem_addr, 32'h100);
        check("t3_req", 32'(bus.imem_req), 32'd1);
        repeat (10) tick();
        check("t3_first_pc", first_pc, 32'h100);

        // Redirect while the 0x40 request is granted.
        lat = 1;
        do_reset();
        saw_pc40 = 1'b0;
        for (int i = 0; i < 60 && !(bus.imem_req && exp_req_pc == 32'h40); i++) tick();
        check("t4_setup", exp_req_pc, 32'h40);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        want_first = 1'b1;
        first_pc = 32'hFFFF_FFFF;
        repeat (10) tick();
        check("t4_no_0x40", 32'(saw_pc40), 32'd0);
        check("t4_first_pc", first_pc, 32'h200);

        // Reset with three requests in flight; their late responses must be ignored.
        lat = 4;
        do_reset();
        for (int i = 0; i < 10 && pend.size() != 3; i++) tick();
        check("t6_setup", 32'(pend.size()), 32'd3);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            check("t6_valid_low", 32'(bus.inst_valid), 32'd0);
            tick();
        end
        check("t6_valid", 32'(bus.inst_valid), 32'd1);
        check("t6_pc", bus.inst_pc, 32'h0);
        check("t6_inst", bus.inst, memfn(32'h0, epoch));
        repeat (8) tick();

        for (int i = 0; i < 100 && !wrap_done; i++) @(posedge clk);
        check("t5_done", 32'(wrap_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Second instance: fetch PC wraps from the top of the address space.
    initial begin : p_wrap
        logic        g_prev;
        logic [31:0] a_prev;
        logic [31:0] exp_q[$];
        logic [31:0] e;
        wrap_done = 1'b0;
        rst2_n = 1'b0;
        bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0;
        bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.inst_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        repeat (2) @(posedge clk);
        #1;
        rst2_n = 1'b1;
        g_prev = 1'b0;
        a_prev = 32'h0;
        for (int i = 0; i < 12; i++) begin
            bus2.imem_gnt    = 1'b1;
            bus2.imem_rvalid = g_prev;
            bus2.imem_rdata  = memfn(a_prev, 0);
            if (bus2.inst_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("t5_pc", bus2.inst_pc, e);
                check("t5_inst", bus2.inst, memfn(e, 0));
            end
            g_prev = bus2.imem_req;
            a_prev = bus2.imem_addr;
            @(posedge clk);
            #1;
        end
        check("t5_all_seen", 32'(exp_q.size()), 32'd0);
        wrap_done = 1'b1;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
